// File: rtl/f1_pkg.sv
// Shared types and constants for the F1 race-start controller.
package f1_pkg;

    localparam int         LFSR_W       = 7;
    localparam logic [7:0] LIGHTS_ALL   = 8'hFF;
    localparam logic [7:0] JUMP_PATTERN = 8'h81;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        SEQ  = 3'd1,
        HOLD = 3'd2,
        OUT  = 3'd3,
        DONE = 3'd4,
        JUMP = 3'd5
    } start_state_t;

    // One step of the x^7+x^6+1 Fibonacci LFSR: shift left, feed back b6^b5.
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] cur);
        return {cur[LFSR_W-2:0], cur[6] ^ cur[5]};
    endfunction

endpackage

// File: rtl/f1_start_timer_if.sv
// Link between the start timer and the upstream light sequencer.
//
// Protocol: there is no valid/ready pair on this link. The sequencer advances
// its thermometer bar by one light on every cycle seq_en is high, and clears to
// all-off on any cycle seq_clr is high (seq_clr wins). lights_in is the
// sequencer's registered bar and is sampled by the timer every cycle.
interface f1_start_timer_if;
    logic       seq_en;
    logic       seq_clr;
    logic [7:0] lights_in;

    // Timer side: drives the sequencer controls, reads the bar.
    modport master (output seq_en, output seq_clr, input lights_in);
    // Sequencer side.
    modport slave  (input seq_en, input seq_clr, output lights_in);
endinterface

// File: rtl/f1_start_timer_lfsr_7.sv
// Free-running 7-bit LFSR that supplies the random hold delay (1..127).
module lfsr_7
    import f1_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = 7'h01
) (
    input  logic              clk,
    input  logic              rst,
    output logic [LFSR_W-1:0] out
);

    logic [LFSR_W-1:0] lfsr_q;
    logic [LFSR_W-1:0] lfsr_d;

    // Next value: advance every cycle, a nonzero seed never reaches zero.
    always_comb begin
        lfsr_d = lfsr_next(lfsr_q);
    end

    // LFSR register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) lfsr_q <= SEED;
        else      lfsr_q <= lfsr_d;
    end

    assign out = lfsr_q;

endmodule

// File: rtl/f1_start_timer.sv
// Race-start controller: gates the light sequencer, holds the full bar for a
// random number of ticks, blanks it, then times the driver's reaction.
module f1_start_timer
    import f1_pkg::*;
#(
    parameter int                TIME_W    = 16,
    parameter logic [LFSR_W-1:0] LFSR_SEED = 7'h01
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                tick,
    input  logic                ms_tick,
    input  logic                start,
    input  logic                trigger,
    f1_start_timer_if.master    seq_if,
    output logic [7:0]          lights_out,
    output logic [TIME_W-1:0]   reaction_time,
    output logic                time_valid,
    output logic                jump_start,
    output start_state_t        state_dbg
);

    start_state_t      state_q, state_d;
    logic [LFSR_W-1:0] delay_q, delay_d;
    logic [TIME_W-1:0] react_q, react_d;
    logic [TIME_W-1:0] reaction_q, reaction_d;
    logic              trig_prev_q, trig_prev_d;
    logic              time_valid_q, time_valid_d;
    logic              jump_start_q, jump_start_d;

    logic [LFSR_W-1:0] lfsr_val;
    logic              trig_edge;

    lfsr_7 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk (clk),
        .rst (rst),
        .out (lfsr_val)
    );

    assign trig_edge = trigger & ~trig_prev_q;

    // Sequencer controls and display bar, decoded from the current state.
    always_comb begin
        seq_if.seq_en  = (state_q == SEQ) & tick;
        seq_if.seq_clr = start & ((state_q == IDLE) | (state_q == DONE) | (state_q == JUMP));
        case (state_q)
            SEQ, HOLD: lights_out = seq_if.lights_in;
            JUMP:      lights_out = JUMP_PATTERN;
            default:   lights_out = 8'h00;
        endcase
    end

    // Next-state, delay counter, reaction counter and capture logic.
    always_comb begin
        state_d      = state_q;
        delay_d      = delay_q;
        react_d      = react_q;
        reaction_d   = reaction_q;
        trig_prev_d  = trigger;
        case (state_q)
            IDLE, DONE, JUMP: begin
                if (start) state_d = SEQ;
            end
            SEQ: begin
                if (trig_edge) begin
                    state_d = JUMP;
                end else if (seq_if.lights_in == LIGHTS_ALL) begin
                    state_d = HOLD;
                    delay_d = lfsr_val;
                end
            end
            HOLD: begin
                // A press in the same cycle as expiry is still a jump start.
                if (trig_edge) begin
                    state_d = JUMP;
                end else if (tick) begin
                    if (delay_q == 7'd1) begin
                        state_d = OUT;
                        react_d = '0;
                    end
                    delay_d = delay_q - 7'd1;
                end
            end
            OUT: begin
                // Capture takes the pre-increment count if ms_tick coincides.
                if (trig_edge) begin
                    state_d    = DONE;
                    reaction_d = react_q;
                end else if (ms_tick && !(&react_q)) begin
                    react_d = react_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        time_valid_d = (state_d == DONE);
        jump_start_d = (state_d == JUMP);
    end

    // State and datapath registers; trigger history resets high so a button
    // held through reset is not seen as a press.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            delay_q      <= '0;
            react_q      <= '0;
            reaction_q   <= '0;
            trig_prev_q  <= 1'b1;
            time_valid_q <= 1'b0;
            jump_start_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            delay_q      <= delay_d;
            react_q      <= react_d;
            reaction_q   <= reaction_d;
            trig_prev_q  <= trig_prev_d;
            time_valid_q <= time_valid_d;
            jump_start_q <= jump_start_d;
        end
    end

    assign reaction_time = reaction_q;
    assign time_valid    = time_valid_q;
    assign jump_start    = jump_start_q;
    assign state_dbg     = state_q;

endmodule

// File: tb/tb_f1_start_timer.sv
// Directed bench for f1_start_timer: a 16-bit and a 4-bit instance run side by
// side on the same stimulus, each with its own light-sequencer model.
module tb_f1_start_timer;
    import f1_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic tick = 1'b0;
    logic ms_tick = 1'b0;
    logic start = 1'b0;
    logic trigger = 1'b0;

    f1_start_timer_if seq_if_a ();
    f1_start_timer_if seq_if_b ();

    logic [7:0]   lights_out_a, lights_out_b;
    logic [15:0]  reaction_a;
    logic [3:0]   reaction_b;
    logic         time_valid_a, time_valid_b;
    logic         jump_a, jump_b;
    start_state_t state_a, state_b;

    logic [7:0]   bar_a, bar_b;
    logic [6:0]   lfsr_m;

    int n_checks = 0;
    int n_errors = 0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog no finish");
        $fatal(1, "watchdog");
    end

    // ---------------- DUTs ----------------
    f1_start_timer #(.TIME_W(16), .LFSR_SEED(7'h01)) dut_a (
        .clk(clk), .rst(rst), .tick(tick), .ms_tick(ms_tick), .start(start),
        .trigger(trigger), .seq_if(seq_if_a), .lights_out(lights_out_a),
        .reaction_time(reaction_a), .time_valid(time_valid_a),
        .jump_start(jump_a), .state_dbg(state_a)
    );

    f1_start_timer #(.TIME_W(4), .LFSR_SEED(7'h01)) dut_b (
        .clk(clk), .rst(rst), .tick(tick), .ms_tick(ms_tick), .start(start),
        .trigger(trigger), .seq_if(seq_if_b), .lights_out(lights_out_b),
        .reaction_time(reaction_b), .time_valid(time_valid_b),
        .jump_start(jump_b), .state_dbg(state_b)
    );

    // ---------------- reference models ----------------
    always @(posedge clk or negedge rst) begin
        if (!rst)                  bar_a <= 8'h00;
        else if (seq_if_a.seq_clr) bar_a <= 8'h00;
        else if (seq_if_a.seq_en)  bar_a <= {bar_a[6:0], 1'b1};
    end
    assign seq_if_a.lights_in = bar_a;

    always @(posedge clk or negedge rst) begin
        if (!rst)                  bar_b <= 8'h00;
        else if (seq_if_b.seq_clr) bar_b <= 8'h00;
        else if (seq_if_b.seq_en)  bar_b <= {bar_b[6:0], 1'b1};
    end
    assign seq_if_b.lights_in = bar_b;

    always @(posedge clk or negedge rst) begin
        if (!rst) lfsr_m <= 7'h01;
        else      lfsr_m <= {lfsr_m[5:0], lfsr_m[6] ^ lfsr_m[5]};
    end

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic next_cyc();
        @(negedge clk);
    endtask

    // Pulse start from IDLE/DONE/JUMP and confirm the clear pulse and SEQ entry.
    task automatic do_start(input string tag);
        start = 1'b1;
        #1;
        check({tag, "_seq_clr"}, 32'(seq_if_a.seq_clr), 32'd1);
        next_cyc();
        start = 1'b0;
        #1;
        check({tag, "_seq_clr_low"}, 32'(seq_if_a.seq_clr), 32'd0);
        check({tag, "_state_seq"}, 32'(state_a), 32'(SEQ));
    endtask

    // Tick every 4 cycles until the bar is full; returns the delay to expect.
    task automatic run_seq(input string tag, output int n);
        logic [7:0] exp_bar;
        exp_bar = 8'h00;
        n = 0;
        for (int k = 0; k < 200; k++) begin
            if (bar_a == 8'hFF) break;
            tick = ((k % 4) == 0);
            #1;
            check({tag, "_seq_en"}, 32'(seq_if_a.seq_en), 32'(tick));
            next_cyc();
            if (tick) begin
                exp_bar = {exp_bar[6:0], 1'b1};
                check({tag, "_bar"}, 32'(lights_out_a), 32'(exp_bar));
            end
            tick = 1'b0;
        end
        check({tag, "_bar_full"}, 32'(bar_a), 32'hFF);
        n = int'(lfsr_m);
        next_cyc();
        check({tag, "_state_hold"}, 32'(state_a), 32'(HOLD));
    endtask

    // Give n hold ticks; lights stay full until the nth, then go dark.
    task automatic run_hold(input string tag, input int n);
        for (int i = 1; i <= n; i++) begin
            tick = 1'b1;
            #1;
            if (i == 1) check({tag, "_seq_en_hold"}, 32'(seq_if_a.seq_en), 32'd0);
            next_cyc();
            tick = 1'b0;
            if (i < n) begin
                check({tag, "_hold_lit"}, 32'(lights_out_a), 32'hFF);
                repeat (3) next_cyc();
            end else begin
                check({tag, "_lights_out"}, 32'(lights_out_a), 32'h00);
                check({tag, "_state_out"}, 32'(state_a), 32'(OUT));
                check({tag, "_state_out_b"}, 32'(state_b), 32'(OUT));
            end
        end
    endtask

    task automatic ms_pulses(input int count);
        for (int i = 0; i < count; i++) begin
            ms_tick = 1'b1;
            next_cyc();
            ms_tick = 1'b0;
            next_cyc();
        end
    endtask

    // ---------------- stimulus ----------------
    int n_delay;

    initial begin
        repeat (2) next_cyc();
        check("rst_state", 32'(state_a), 32'(IDLE));
        check("rst_lights", 32'(lights_out_a), 32'h00);
        check("rst_seq_en", 32'(seq_if_a.seq_en), 32'd0);
        check("rst_seq_clr", 32'(seq_if_a.seq_clr), 32'd0);
        check("rst_reaction", 32'(reaction_a), 32'd0);
        check("rst_valid", 32'(time_valid_a), 32'd0);
        check("rst_jump", 32'(jump_a), 32'd0);
        rst = 1'b1;
        repeat (3) next_cyc();

        // Race A: normal run, reaction of 237 ms (saturates at 15 on 4-bit DUT).
        do_start("a");
        run_seq("a", n_delay);
        run_hold("a", n_delay);
        ms_pulses(237);
        trigger = 1'b1;
        #1;
        check("a_valid_before", 32'(time_valid_a), 32'd0);
        next_cyc();
        check("a_valid", 32'(time_valid_a), 32'd1);
        check("a_reaction", 32'(reaction_a), 32'd237);
        check("a_state_done", 32'(state_a), 32'(DONE));
        check("a_reaction_sat", 32'(reaction_b), 32'd15);
        check("a_valid_b", 32'(time_valid_b), 32'd1);
        trigger = 1'b0;
        next_cyc();

        // Race B: jump start in HOLD, then restart.
        do_start("b");
        run_seq("b", n_delay);
        trigger = 1'b1;
        next_cyc();
        check("b_jump", 32'(jump_a), 32'd1);
        check("b_lights", 32'(lights_out_a), 32'h81);
        check("b_valid", 32'(time_valid_a), 32'd0);
        check("b_reaction_kept", 32'(reaction_a), 32'd237);
        check("b_state", 32'(state_a), 32'(JUMP));
        trigger = 1'b0;
        next_cyc();
        do_start("b2");
        check("b2_jump_low", 32'(jump_a), 32'd0);

        // Race C: press on the same tick that would end the hold -> jump.
        run_seq("c", n_delay);
        for (int i = 0; i < n_delay - 1; i++) begin
            tick = 1'b1;
            next_cyc();
            tick = 1'b0;
            check("c_hold_lit", 32'(lights_out_a), 32'hFF);
            repeat (3) next_cyc();
        end
        tick = 1'b1;
        trigger = 1'b1;
        next_cyc();
        tick = 1'b0;
        trigger = 1'b0;
        check("c_state_jump", 32'(state_a), 32'(JUMP));
        check("c_lights", 32'(lights_out_a), 32'h81);
        next_cyc();

        // Race D: reset mid-HOLD with trigger held, then held trigger into OUT.
        do_start("d");
        run_seq("d", n_delay);
        rst = 1'b0;
        trigger = 1'b1;
        tick = 1'b1;
        #1;
        check("d_rst_state", 32'(state_a), 32'(IDLE));
        check("d_rst_lights", 32'(lights_out_a), 32'h00);
        check("d_rst_seq_en", 32'(seq_if_a.seq_en), 32'd0);
        check("d_rst_reaction", 32'(reaction_a), 32'd0);
        check("d_rst_valid", 32'(time_valid_a), 32'd0);
        check("d_rst_jump", 32'(jump_a), 32'd0);
        repeat (2) next_cyc();
        tick = 1'b0;
        rst = 1'b1;
        next_cyc();
        do_start("e");
        run_seq("e", n_delay);
        run_hold("e", n_delay);
        ms_pulses(3);
        check("e_held_no_capture", 32'(state_a), 32'(OUT));
        check("e_held_valid", 32'(time_valid_a), 32'd0);
        trigger = 1'b0;
        next_cyc();
        ms_pulses(17);
        ms_tick = 1'b1;
        trigger = 1'b1;
        next_cyc();
        ms_tick = 1'b0;
        check("e_pre_inc", 32'(reaction_a), 32'd20);
        check("e_valid", 32'(time_valid_a), 32'd1);
        check("e_sat", 32'(reaction_b), 32'd15);
        trigger = 1'b0;
        next_cyc();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/f1_start_timer.md
# f1_start_timer

Race-start controller directly downstream of the F1 light-sequencer FSM. It consumes the sequencer's 8-bit light bar and gates its enable. Once all eight lights are lit, it holds them for a pseudo-random number of ticks, then turns them out. It then measures the driver's reaction time in millisecond ticks until the trigger is pressed, and flags jump starts.

## Interface
Parameters:
- `TIME_W`, 16: reaction-counter width in ms ticks.
- `LFSR_SEED`, 7'h01: LFSR reset value; must be nonzero.

Ports:
- `clk` in 1: system clock, all logic on rising edge.
- `rst` in 1: reset, asynchronous and active-low.
- `tick` in 1: one-cycle pulse that paces the light sequence and hold delay.
- `ms_tick` in 1: one-cycle pulse every 1 ms, paces the reaction counter.
- `start` in 1: level, sampled each cycle; requests a new race start.
- `trigger` in 1: driver button, already synchronized; edge-detected internally.
- `lights_in` in 8: light bar from the sequencer (thermometer code 0x00..0xFF).
- `seq_en` out 1: enable to the sequencer; equals `tick` while in SEQ, else 0.
- `seq_clr` out 1: one-cycle pulse that resets the sequencer to all-off.
- `lights_out` out 8: bar driven to the display.
- `reaction_time` out TIME_W: captured reaction time in ms ticks.
- `time_valid` out 1: `reaction_time` valid; high throughout DONE.
- `jump_start` out 1: high throughout JUMP.

## Operation
- States: IDLE, SEQ, HOLD, OUT, DONE, JUMP.
- IDLE:
  - `start`=1 → SEQ; `seq_clr` pulses high in the transition cycle.
  - DONE and JUMP also go to SEQ on `start`=1, with the same `seq_clr` pulse.
  - `start` is ignored in SEQ, HOLD and OUT.
- SEQ:
  - `seq_en`=`tick`.
  - When `lights_in`==8'hFF → HOLD. The delay counter loads the current LFSR value (1..127) on that transition.
  - `seq_en` is 0 from HOLD onward, so the sequencer holds 0xFF.
- HOLD: the delay counter decrements on `tick`. A `tick` with counter==1 → OUT.
- OUT:
  - The reaction counter is cleared on entry.
  - It increments on `ms_tick` and saturates at all-ones.
  - A trigger rising edge → DONE, and `reaction_time` captures the counter.
  - If the trigger edge and `ms_tick` occur in the same cycle, the pre-increment value is captured.
- DONE:
  - `time_valid`=1.
  - `reaction_time` holds until the next capture or reset.
- JUMP:
  - Entered on a trigger rising edge in SEQ or HOLD.
  - `jump_start`=1; `reaction_time` is unchanged and `time_valid`=0.
- Trigger edge: `trigger`=1 while the registered previous `trigger`=0.
  - The edge register resets to 1, so a button held through reset produces no edge.
  - Edges in IDLE, DONE and JUMP are ignored.
- `lights_out` (combinational from state):
  - SEQ, HOLD: `lights_in`.
  - IDLE, OUT, DONE: 8'h00.
  - JUMP: 8'h81.
- LFSR:
  - 7-bit Fibonacci, polynomial x^7+x^6+1: shift left, new bit = b6^b5.
  - Advances every `clk` cycle, including in IDLE.
  - Resets to LFSR_SEED and never reaches zero.
- Priority: a trigger edge in HOLD takes precedence over HOLD expiry in the same cycle → JUMP.

## Timing
- Reset values: state IDLE, all outputs 0, counters 0, LFSR=LFSR_SEED.
- `rst` assertion mid-race returns to IDLE immediately (asynchronous). `seq_clr` is not pulsed; the sequencer is reset by its own reset.
- `start` → `seq_clr` same cycle (combinational from state and `start`); SEQ is active next cycle.
- `lights_in`==0xFF → HOLD next cycle; `seq_en` is 0 in that cycle and after.
- Hold duration: exactly N `tick` pulses, where N is the loaded LFSR value. Lights go out in the cycle after the Nth tick.
- Trigger edge in OUT → DONE and `time_valid`=1 in the next cycle.
- Latency from trigger edge to `time_valid`: 1 cycle.

## Structure
- Package `f1_pkg`: state enum `start_state_t`, `LIGHTS_ALL`=8'hFF, `JUMP_PATTERN`=8'h81, `LFSR_W`=7.
- Sub-module `lfsr_7` (ports clk, rst, out[6:0]; parameter SEED), instantiated once.
- The remaining logic (state register, delay counter, reaction counter, edge detect) lives in `f1_start_timer`.

## Test plan
- Normal run:
  - Reset, pulse `start`, drive `tick` every 4 cycles, model the sequencer from `seq_en`/`seq_clr`.
  - Expect `lights_out` 0x01→0xFF, `seq_en` 0 after 0xFF, and lights 0x00 after exactly N ticks, where N is the LFSR value at HOLD entry.
- Reaction capture:
  - Assert `trigger` after 237 `ms_tick` pulses in OUT.
  - Expect `reaction_time`=237 and `time_valid`=1 one cycle later.
- Jump start:
  - Trigger edge in HOLD → `jump_start`=1, `lights_out`=0x81, `time_valid`=0.
  - Then `start` → SEQ with a `seq_clr` pulse.
- Boundaries:
  - Trigger edge coincident with `ms_tick` captures the pre-increment value.
  - Use TIME_W=4 with 20 `ms_tick` pulses: saturates at 15.
- Held trigger and reset:
  - `trigger` held high across reset and into OUT gives no capture until released and re-pressed.
  - `rst` low mid-HOLD → all outputs 0 and IDLE immediately.
